// File: rtl/tv80_mcycle_seq_pkg.sv
// Types and helpers for the TV80 M-cycle/T-state sequencer.
package tv80_mcycle_seq_pkg;
  `include "tv80_seq_defs.vh"

  typedef enum logic [1:0] {
    ST_RUN     = SEQ_RUN,
    ST_WAIT    = SEQ_WAIT,
    ST_BUSHOLD = SEQ_BUSHOLD
  } seq_state_t;

  // Decoder may report short/zero lengths; the bus needs at least T1..T3.
  function automatic logic [2:0] eff_tstates(input logic [2:0] t);
    return (t < MIN_TSTATES) ? MIN_TSTATES : t;
  endfunction

  function automatic logic [2:0] eff_mcycles(input logic [2:0] m);
    return (m == 3'd0) ? 3'd1 : m;
  endfunction
endpackage

// File: rtl/tv80_irq_latch.sv
// NMI edge latch and INT/NMI acknowledge flags, updated at instruction boundaries.
module tv80_irq_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic cen,
  input  logic nmi_n,
  input  logic int_n,
  input  logic iff1,
  input  logic boundary,
  output logic irq_take,
  output logic int_cycle,
  output logic nmi_cycle
);
  logic nmi_q, nmi_pend, nmi_fall, int_ok;

  assign nmi_fall = cen && nmi_q && !nmi_n;
  assign int_ok   = !int_n && iff1;
  assign irq_take = boundary && (nmi_pend || int_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_q     <= 1'b1;
      nmi_pend  <= 1'b0;
      int_cycle <= 1'b0;
      nmi_cycle <= 1'b0;
    end else begin
      if (cen) nmi_q <= nmi_n;
      // A fresh edge wins over consumption so it is never lost.
      if (nmi_fall) nmi_pend <= 1'b1;
      else if (boundary && nmi_pend) nmi_pend <= 1'b0;
      if (boundary) begin
        nmi_cycle <= nmi_pend;
        int_cycle <= !nmi_pend && int_ok;
      end
    end
  end
endmodule

// File: rtl/tv80_seq_defs.vh
// Shared encodings for the M-cycle/T-state sequencer.
`ifndef TV80_SEQ_DEFS_VH
`define TV80_SEQ_DEFS_VH
localparam logic [1:0] SEQ_RUN     = 2'd0;
localparam logic [1:0] SEQ_WAIT    = 2'd1;
localparam logic [1:0] SEQ_BUSHOLD = 2'd2;
localparam logic [6:0] M1_ONEHOT   = 7'h01;
localparam logic [6:0] T1_ONEHOT   = 7'h01;
localparam logic [2:0] MIN_TSTATES = 3'd3;
`endif

// File: rtl/tv80_mcycle_seq.sv
// TV80 machine-cycle/T-state sequencer: one-hot M/T counters, wait and bus-hold
// insertion, halt tracking and interrupt acknowledge flags.
module tv80_mcycle_seq
  import tv80_mcycle_seq_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       wait_n,
  input  logic       busrq_n,
  input  logic       int_n,
  input  logic       nmi_n,
  input  logic       iff1,
  input  logic [2:0] mcycles,
  input  logic [2:0] tstates,
  input  logic       halt,
  output logic [6:0] mcycle,
  output logic [6:0] tstate,
  output logic       last_t,
  output logic       last_m,
  output logic       m1_n,
  output logic       halt_n,
  output logic       busak_n,
  output logic       int_cycle,
  output logic       nmi_cycle,
  output logic       new_instr
);
  localparam bit USE_WAIT = (MODE < 2);

  seq_state_t st, st_nx;
  logic [6:0] mcycle_nx, tstate_nx;
  logic       halt_n_nx, boundary, irq_take;

  assign last_t    = tstate[eff_tstates(tstates) - 3'd1];
  assign last_m    = mcycle[eff_mcycles(mcycles) - 3'd1];
  assign boundary  = (st == ST_RUN) && cen && last_t && last_m;
  assign m1_n      = !(mcycle[0] && (tstate[0] || tstate[1]));
  assign busak_n   = (st != ST_BUSHOLD);
  assign new_instr = cen && (st == ST_RUN) && mcycle[0] && tstate[0];

  tv80_irq_latch u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .cen       (cen),
    .nmi_n     (nmi_n),
    .int_n     (int_n),
    .iff1      (iff1),
    .boundary  (boundary),
    .irq_take  (irq_take),
    .int_cycle (int_cycle),
    .nmi_cycle (nmi_cycle)
  );

  always_comb begin
    st_nx     = st;
    mcycle_nx = mcycle;
    tstate_nx = tstate;
    halt_n_nx = halt_n;
    if (cen) begin
      unique case (st)
        ST_RUN: begin
          if (last_t) begin
            tstate_nx = T1_ONEHOT;
            mcycle_nx = last_m ? M1_ONEHOT : (mcycle << 1);
            if (!busrq_n) st_nx = ST_BUSHOLD;
            if (boundary) begin
              if (irq_take) halt_n_nx = 1'b1;
              else if (halt) halt_n_nx = 1'b0;
            end
          end else if (USE_WAIT && tstate[1] && !wait_n) begin
            st_nx = ST_WAIT;
          end else begin
            tstate_nx = tstate << 1;
          end
        end
        // Leaving WAIT completes T2, so T3 starts on the same edge.
        ST_WAIT: begin
          if (wait_n) begin
            st_nx     = ST_RUN;
            tstate_nx = tstate << 1;
          end
        end
        ST_BUSHOLD: begin
          if (busrq_n) st_nx = ST_RUN;
        end
        default: st_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= ST_RUN;
      mcycle <= M1_ONEHOT;
      tstate <= T1_ONEHOT;
      halt_n <= 1'b1;
    end else begin
      st     <= st_nx;
      mcycle <= mcycle_nx;
      tstate <= tstate_nx;
      halt_n <= halt_n_nx;
    end
  end
endmodule

// File: tb/tb_tv80_mcycle_seq.sv
// Directed bench for tv80_mcycle_seq; a MODE=2 copy shares the inputs.
module tb_tv80_mcycle_seq;
  logic clk, reset_n, cen, wait_n, busrq_n, int_n, nmi_n, iff1, halt;
  logic [2:0] mcycles, tstates;
  logic [6:0] mcycle, tstate;
  logic last_t, last_m, m1_n, halt_n, busak_n, int_cycle, nmi_cycle, new_instr;
  logic [6:0] m2_mcycle, m2_tstate;
  logic m2_last_t, m2_last_m, m2_m1_n, m2_halt_n, m2_busak_n, m2_int_cycle;
  logic m2_nmi_cycle, m2_new_instr;
  int checks = 0;
  int errors = 0;

  tv80_mcycle_seq #(.MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wait_n(wait_n), .busrq_n(busrq_n),
    .int_n(int_n), .nmi_n(nmi_n), .iff1(iff1), .mcycles(mcycles), .tstates(tstates),
    .halt(halt), .mcycle(mcycle), .tstate(tstate), .last_t(last_t), .last_m(last_m),
    .m1_n(m1_n), .halt_n(halt_n), .busak_n(busak_n), .int_cycle(int_cycle),
    .nmi_cycle(nmi_cycle), .new_instr(new_instr)
  );

  tv80_mcycle_seq #(.MODE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wait_n(wait_n), .busrq_n(busrq_n),
    .int_n(int_n), .nmi_n(nmi_n), .iff1(iff1), .mcycles(mcycles), .tstates(tstates),
    .halt(halt), .mcycle(m2_mcycle), .tstate(m2_tstate), .last_t(m2_last_t),
    .last_m(m2_last_m), .m1_n(m2_m1_n), .halt_n(m2_halt_n), .busak_n(m2_busak_n),
    .int_cycle(m2_int_cycle), .nmi_cycle(m2_nmi_cycle), .new_instr(m2_new_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cen = 1'b1; wait_n = 1'b1; busrq_n = 1'b1; int_n = 1'b1; nmi_n = 1'b1;
    iff1 = 1'b0; halt = 1'b0; mcycles = 3'd1; tstates = 3'd3;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [6:0] w0_exp [5];
  logic [6:0] w2_exp [5];

  initial begin
    // Normal counting, mcycles=3, tstates=4
    do_reset();
    mcycles = 3'd3; tstates = 3'd4;
    chk("rst_halt_n", {7'd0, halt_n}, 8'd1);
    chk("rst_busak_n", {7'd0, busak_n}, 8'd1);
    chk("rst_int_cycle", {7'd0, int_cycle}, 8'd0);
    chk("rst_nmi_cycle", {7'd0, nmi_cycle}, 8'd0);
    for (int k = 0; k <= 12; k++) begin
      chk("run_tstate", {1'b0, tstate}, 8'(1 << (k % 4)));
      chk("run_mcycle", {1'b0, mcycle}, 8'(1 << ((k / 4) % 3)));
      chk("run_last_t", {7'd0, last_t}, 8'((k % 4) == 3));
      chk("run_new_instr", {7'd0, new_instr}, 8'((k % 12) == 0));
      chk("run_m1_n", {7'd0, m1_n}, 8'((k % 12) >= 2));
      if (k < 12) tick(1);
    end

    // Clamping: tstates=2 -> 3, mcycles=0 -> 1
    do_reset();
    mcycles = 3'd0; tstates = 3'd2;
    for (int k = 0; k <= 6; k++) begin
      chk("clamp_tstate", {1'b0, tstate}, 8'(1 << (k % 3)));
      chk("clamp_mcycle", {1'b0, mcycle}, 8'h01);
      chk("clamp_last_m", {7'd0, last_m}, 8'd1);
      chk("clamp_new_instr", {7'd0, new_instr}, 8'((k % 3) == 0));
      if (k < 6) tick(1);
    end

    // Wait insertion: MODE=0 stretches T2, MODE=2 ignores wait_n
    do_reset();
    mcycles = 3'd1; tstates = 3'd4;
    w0_exp = '{7'h02, 7'h02, 7'h02, 7'h02, 7'h04};
    w2_exp = '{7'h02, 7'h04, 7'h08, 7'h01, 7'h02};
    tick(1);
    wait_n = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) wait_n = 1'b1;
      chk("wait_m0_tstate", {1'b0, tstate}, {1'b0, w0_exp[k-1]});
      chk("wait_m2_tstate", {1'b0, m2_tstate}, {1'b0, w2_exp[k-1]});
      if (k < 5) tick(1);
    end

    // Bus request during M2
    do_reset();
    mcycles = 3'd3; tstates = 3'd4;
    tick(5);
    busrq_n = 1'b0;
    chk("bus_m2t2_mcycle", {1'b0, mcycle}, 8'h02);
    tick(2);
    chk("bus_lastt_busak", {7'd0, busak_n}, 8'd1);
    chk("bus_lastt", {7'd0, last_t}, 8'd1);
    for (int k = 8; k <= 10; k++) begin
      tick(1);
      chk("bus_hold_busak", {7'd0, busak_n}, 8'd0);
      chk("bus_hold_mcycle", {1'b0, mcycle}, 8'h04);
      chk("bus_hold_tstate", {1'b0, tstate}, 8'h01);
    end
    busrq_n = 1'b1;
    tick(1);
    chk("bus_rel_busak", {7'd0, busak_n}, 8'd1);
    chk("bus_rel_tstate", {1'b0, tstate}, 8'h01);
    tick(1);
    chk("bus_resume_tstate", {1'b0, tstate}, 8'h02);
    chk("bus_resume_mcycle", {1'b0, mcycle}, 8'h04);

    // Halt released by INT (iff1=1), then halt held with iff1=0
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mcycles = 3'd1; tstates = 3'd3; iff1 = (pass == 0); halt = 1'b1;
      tick(2);
      chk("halt_pre_halt_n", {7'd0, halt_n}, 8'd1);
      tick(1);
      halt = 1'b0;
      chk("halt_enter", {7'd0, halt_n}, 8'd0);
      tick(3);
      chk("halt_hold", {7'd0, halt_n}, 8'd0);
      chk("halt_m1_repeat", {1'b0, mcycle}, 8'h01);
      chk("halt_new_instr", {7'd0, new_instr}, 8'd1);
      int_n = 1'b0;
      tick(2);
      chk("halt_pre_int", {7'd0, int_cycle}, 8'd0);
      tick(1);
      chk("halt_int_cycle", {7'd0, int_cycle}, 8'(pass == 0));
      chk("halt_exit", {7'd0, halt_n}, 8'(pass == 0));
      int_n = 1'b1;
    end

    // NMI beats INT, INT follows; then async reset mid-M2
    do_reset();
    mcycles = 3'd2; tstates = 3'd3; iff1 = 1'b1;
    tick(1);
    nmi_n = 1'b0; int_n = 1'b0;
    tick(5);
    chk("nmi_cycle", {7'd0, nmi_cycle}, 8'd1);
    chk("nmi_int_cycle", {7'd0, int_cycle}, 8'd0);
    tick(5);
    chk("nmi_hold", {7'd0, nmi_cycle}, 8'd1);
    tick(1);
    chk("nmi_next_int", {7'd0, int_cycle}, 8'd1);
    chk("nmi_next_nmi", {7'd0, nmi_cycle}, 8'd0);
    tick(4);
    chk("pre_rst_mcycle", {1'b0, mcycle}, 8'h02);
    reset_n = 1'b0;
    #1;
    chk("arst_mcycle", {1'b0, mcycle}, 8'h01);
    chk("arst_tstate", {1'b0, tstate}, 8'h01);
    chk("arst_int_cycle", {7'd0, int_cycle}, 8'd0);
    chk("arst_nmi_cycle", {7'd0, nmi_cycle}, 8'd0);
    chk("arst_halt_n", {7'd0, halt_n}, 8'd1);
    chk("arst_busak_n", {7'd0, busak_n}, 8'd1);
    chk("arst_m1_n", {7'd0, m1_n}, 8'd0);
    chk("arst_new_instr", {7'd0, new_instr}, 8'd1);
    reset_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tv80_mcycle_seq.md
Name: tv80_mcycle_seq

Overview:
Machine-cycle/T-state sequencer that consumes the per-cycle MCycles/TStates/Halt fields produced by the TV80 microcode decoder. It generates the one-hot MCycle and tstate vectors the decoder is indexed by, and inserts wait states. It also arbitrates bus request/acknowledge, samples INT/NMI at instruction boundaries, and drives IntCycle/NMICycle back to the decoder. It sits between the decoder and the bus/register control in the core.

Parameters:
Mode, 0, CPU flavour; 0/1 = Z80 (wait sampled at T2), 2/3 = GB/8080-style (no wait insertion; wait_n ignored).

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; all state advances only when cen=1
wait_n  in  1  external wait request, active-low
busrq_n  in  1  bus request, active-low
int_n  in  1  maskable interrupt, level, active-low
nmi_n  in  1  non-maskable interrupt, falling-edge
iff1  in  1  interrupt enable flip-flop
mcycles  in  3  decoder MCycles: number of M-cycles in the current instruction
tstates  in  3  decoder TStates: length of the current M-cycle
halt  in  1  decoder Halt, qualified at the last T of the last M-cycle
mcycle  out  7  one-hot M-cycle, bit0=M1
tstate  out  7  one-hot T-state, bit0=T1
last_t  out  1  current T is the final T of this M-cycle
last_m  out  1  current M-cycle is the instruction's last
m1_n  out  1  low during M1 T1..T2
halt_n  out  1  low while halted
busak_n  out  1  bus acknowledge, active-low
int_cycle  out  1  current instruction is an INT acknowledge
nmi_cycle  out  1  current instruction is an NMI acknowledge
new_instr  out  1  one-cycle pulse at M1 T1 when cen=1

Behaviour:
- Reset values: mcycle=7'h01, tstate=7'h01, halt_n=1, busak_n=1, int_cycle=0, nmi_cycle=0, nmi latch cleared. Derived outputs follow from this state (m1_n=0, new_instr=1 when cen=1).
- Clamping: tstates 0..2 are treated as 3. mcycles 0 is treated as 1. The registered state holds the one-hot vectors; outputs are combinational from state plus inputs.
- last_t = tstate[eff_tstates-1]. last_m = mcycle[eff_mcycles-1]. Both are evaluated combinationally every cycle; the decoder may change tstates per M-cycle.
- States: RUN, WAIT, BUSHOLD.
- RUN, cen=1, not last_t: tstate shifts left by 1.
- RUN, cen=1, last_t: tstate returns to T1. mcycle shifts left, or returns to M1 if last_m.
- Wait insertion (Mode<2): in RUN at T2 with wait_n=0 and cen=1, go to WAIT and hold tstate=T2. WAIT returns to RUN on the first cen cycle with wait_n=1; tstate then advances to T3 on that same edge. Unlimited wait length.
- Bus request: busrq_n is sampled only at last_t&cen. If it is 0, the normal advance still happens, then the block enters BUSHOLD with busak_n=0 from the next cycle. mcycle/tstate stay frozen at the next T1. BUSHOLD exits on a cen cycle with busrq_n=1; busak_n returns to 1 on the same edge. Bus request has priority over wait.
- NMI: a falling edge of nmi_n, sampled on clk with cen, sets the nmi latch. The latch holds until consumed.
- Interrupt sampling happens at last_t&last_m&cen:
  - nmi latch set: nmi_cycle=1, int_cycle=0, latch cleared.
  - else if int_n=0 and iff1=1: int_cycle=1.
  - else both cleared.
  - Both flags are held for the whole following instruction.
- Halt: at last_t&last_m&cen with halt=1, halt_n goes to 0. While halted, M1 cycles repeat (the decoder sees a NOP; the sequencer simply keeps cycling). halt_n returns to 1 at the boundary where nmi_cycle or int_cycle becomes 1.
- Simultaneous events at one boundary: NMI beats INT; the bus request is still granted, and the interrupt flags persist across BUSHOLD.
- reset_n low mid-operation returns everything to reset values immediately; no partial cycle completes.

Decomposition:
- Include file tv80_seq_defs.vh: state encodings (RUN/WAIT/BUSHOLD), M1/T1 one-hot constants, minimum T-state constant 3.
- One sub-module, tv80_irq_latch: NMI edge detect/latch, INT qualification with iff1, priority, and the int_cycle/nmi_cycle registers.

Test Plan:
- Reset, then mcycles=3, tstates=4, cen=1: mcycle goes 01→02→04→01 every 4 clocks; tstate goes 01,02,04,08; last_t pulses every 4th clock; new_instr every 12 clocks.
- tstates=2 (clamped to 3), mcycles=0 (clamped to 1): tstate cycles 01,02,04; mcycle stays 01; new_instr every 3 clocks.
- wait_n=0 for 3 clocks at T2 (Mode=0): tstate stays 02 for 4 clocks, then 04. Repeat with Mode=2: no stretch.
- busrq_n=0 asserted at T2 of M2: busak_n falls one clock after that M-cycle's last_t; mcycle=04, tstate=01 frozen. Release busrq_n: busak_n=1, counting resumes.
- halt=1 at instruction end, then int_n=0 with iff1=1: halt_n=0 with M1 repeating; at the next boundary int_cycle=1 and halt_n=1. Same run with iff1=0: halt persists.
- nmi_n falling edge with int_n=0, iff1=1 in the same instruction: nmi_cycle=1, int_cycle=0. In the following instruction int_cycle=1. Assert reset_n=0 mid-M2: outputs match reset values within the same cycle.
